im_boot_loader: RTL and testbench



---
 rtl/im_boot_loader.sv | 122 ++++++++++++
 tb/tb_im_boot_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/im_boot_loader.sv
// Byte-stream boot loader: packs bytes into 32-bit words, writes them to the
// instruction memory and holds the mips core in reset until the program is in.
module im_boot_loader #(
   parameter int ADDR_WIDTH = 10,
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_start,
   input  logic [ADDR_WIDTH:0]   load_len,
   input  logic                  in_valid,
   input  logic [7:0]            in_byte,
   output logic                  in_ready,
   output logic                  im_we,
   output logic [ADDR_WIDTH-1:0] im_addr,
   output logic [31:0]           im_wdata,
   output logic                  cpu_rst,
   output logic                  busy,
   output logic                  done,
   output logic [31:0]           checksum
);

   // state | meaning
   // IDLE  | after reset, core held in reset, waiting for load_start
   // RECV  | accepting bytes of the current word
   // WRITE | one-cycle memory write of the assembled word
   // DONE  | program loaded, core released, waiting for a reload
   typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

   localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};

   state_t                state;
   logic [1:0]            byte_cnt;
   logic [ADDR_WIDTH-1:0] word_idx;
   logic [ADDR_WIDTH:0]   len_q;
   logic [31:0]           asm_q;
   logic [31:0]           asm_nxt;
   logic [ADDR_WIDTH:0]   start_len;
   logic                  last_word;
   logic                  take;

   always_comb begin
      asm_nxt   = BIG_ENDIAN ? {asm_q[23:0], in_byte} : {in_byte, asm_q[31:8]};
      start_len = (load_len > MAX_LEN) ? MAX_LEN : load_len;
      last_word = (({1'b0, word_idx} + ONE) == len_q);
      take      = in_valid && in_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         byte_cnt <= 2'd0;
         word_idx <= '0;
         len_q    <= '0;
         asm_q    <= 32'd0;
         in_ready <= 1'b0;
         im_we    <= 1'b0;
         im_addr  <= '0;
         im_wdata <= 32'd0;
         cpu_rst  <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         checksum <= 32'd0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (load_start) begin
                  checksum <= 32'd0;
                  if (load_len == '0) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     cpu_rst  <= 1'b0;
                     busy     <= 1'b0;
                     in_ready <= 1'b0;
                  end else begin
                     state    <= RECV;
                     len_q    <= start_len;
                     word_idx <= '0;
                     byte_cnt <= 2'd0;
                     asm_q    <= 32'd0;
                     busy     <= 1'b1;
                     in_ready <= 1'b1;
                     done     <= 1'b0;
                     cpu_rst  <= 1'b1;
                  end
               end
            end
            RECV: begin
               if (take) begin
                  asm_q    <= asm_nxt;
                  byte_cnt <= byte_cnt + 2'd1;
                  // ready drops on the fourth byte so a fifth cannot slip in
                  if (byte_cnt == 2'd3) begin
                     in_ready <= 1'b0;
                     im_wdata <= asm_nxt;
                     im_addr  <= word_idx;
                     im_we    <= 1'b1;
                     state    <= WRITE;
                  end
               end
            end
            WRITE: begin
               im_we    <= 1'b0;
               checksum <= checksum + im_wdata;
               if (last_word) begin
                  state   <= DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  cpu_rst <= 1'b0;
               end else begin
                  word_idx <= word_idx + 1'b1;
                  in_ready <= 1'b1;
                  state    <= RECV;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_im_boot_loader.sv
// Bench for im_boot_loader: big- and little-endian instances share one byte
// stream; expected writes are queued as words are driven and popped on im_we.
module tb_im_boot_loader;
   localparam int AW    = 10;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst, load_start, in_valid;
   logic [AW:0]   load_len;
   logic [7:0]    in_byte;
   logic          in_ready, im_we, cpu_rst, busy, done;
   logic [AW-1:0] im_addr;
   logic [31:0]   im_wdata, checksum;
   logic          in_ready_l, im_we_l, cpu_rst_l, busy_l, done_l;
   logic [AW-1:0] im_addr_l;
   logic [31:0]   im_wdata_l, checksum_l;

   im_boot_loader #(.ADDR_WIDTH(AW), .BIG_ENDIAN(1'b1)) dut_be (
      .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
      .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
      .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .cpu_rst(cpu_rst),
      .busy(busy), .done(done), .checksum(checksum));

   im_boot_loader #(.ADDR_WIDTH(AW), .BIG_ENDIAN(1'b0)) dut_le (
      .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
      .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready_l),
      .im_we(im_we_l), .im_addr(im_addr_l), .im_wdata(im_wdata_l), .cpu_rst(cpu_rst_l),
      .busy(busy_l), .done(done_l), .checksum(checksum_l));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } exp_t;

   typedef struct {
      int          len;
      int          nwords;
      int          gap;
      bit          fixed;
      logic [31:0] first;
      int          exp_writes;
   } vec_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [31:0] words [DEPTH];
   logic [31:0] mem   [DEPTH];
   logic [31:0] sum_be, sum_le;
   int          checks = 0, failures = 0;
   int          wr_count, last_addr, prev_we_cyc, done_cyc, busy_low;
   bit          spacing_chk;
   vec_t        vecs [6];

   function automatic logic [31:0] bswap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (im_we || im_we_l) begin
         chk("we_match", {63'd0, im_we_l}, {63'd0, im_we});
         chk("ready_low_in_write", {63'd0, in_ready}, 64'd0);
         chk("sb_pending", {63'd0, sb.size() != 0}, 64'd1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("wr_addr", {54'd0, im_addr}, {54'd0, mon_e.addr});
            chk("wr_data_be", {32'd0, im_wdata}, {32'd0, mon_e.data});
            chk("wr_addr_le", {54'd0, im_addr_l}, {54'd0, mon_e.addr});
            chk("wr_data_le", {32'd0, im_wdata_l}, {32'd0, bswap(mon_e.data)});
         end
         mem[im_addr] = im_wdata;
         if (spacing_chk && wr_count > 0)
            chk("word_spacing", 64'(cyc - prev_we_cyc), 64'd5);
         prev_we_cyc = cyc;
         last_addr   = int'(im_addr);
         wr_count++;
      end
   end

   // Drives bytes first..last-1 of words[]; a byte offered while not ready is held.
   task automatic send_bytes(input int first, input int last, input int gap);
      int   idx;
      int   budget;
      logic rdy_prev;
      exp_t e;
      idx      = first;
      budget   = 0;
      rdy_prev = 1'b0;
      in_valid = 1'b0;
      while (idx < last && budget < 20000) begin
         if (!(in_valid && !rdy_prev)) begin
            if (gap > 0 && $urandom_range(99) < gap) begin
               in_valid = 1'b0;
            end else begin
               in_valid = 1'b1;
               in_byte  = words[idx/4][31-8*(idx%4) -: 8];
               if (idx % 4 == 3) begin
                  e.addr = AW'(idx/4);
                  e.data = words[idx/4];
                  sb.push_back(e);
                  sum_be += e.data;
                  sum_le += bswap(e.data);
               end
            end
         end
         rdy_prev = in_ready;
         @(negedge clk);
         budget++;
         if (!busy) busy_low++;
         if (in_valid && rdy_prev) idx++;
      end
      in_valid = 1'b0;
      chk("bytes_sent", 64'(idx), 64'(last));
   endtask

   task automatic start_load(input int len);
      load_len   = (AW+1)'(len);
      load_start = 1'b1;
      wr_count   = 0;
      busy_low   = 0;
      sum_be     = 32'd0;
      sum_le     = 32'd0;
      @(negedge clk);
      load_start = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", {63'd0, done}, 64'd1);
      done_cyc = cyc;
   endtask

   task automatic run_vec(input vec_t v);
      int bad;
      for (int i = 0; i < v.nwords; i++) words[i] = $urandom;
      if (v.fixed) words[0] = v.first;
      spacing_chk = (v.gap == 0);
      start_load(v.len);
      if (v.len == 0) begin
         chk("zero_done", {63'd0, done}, 64'd1);
         chk("zero_cpu_rst", {63'd0, cpu_rst}, 64'd0);
         chk("zero_checksum", {32'd0, checksum}, 64'd0);
      end else begin
         chk("start_ctrl", {60'd0, cpu_rst, busy, in_ready, done}, {60'd0, 4'b1110});
      end
      send_bytes(0, 4*v.nwords, v.gap);
      wait_done();
      chk("write_count", 64'(wr_count), 64'(v.exp_writes));
      chk("checksum_be", {32'd0, checksum}, {32'd0, sum_be});
      chk("checksum_le", {32'd0, checksum_l}, {32'd0, sum_le});
      chk("end_ctrl", {60'd0, cpu_rst, busy, in_ready, done}, {60'd0, 4'b0001});
      chk("end_ctrl_le", {60'd0, cpu_rst_l, busy_l, in_ready_l, done_l}, {60'd0, 4'b0001});
      chk("sb_drained", 64'(sb.size()), 64'd0);
      if (v.exp_writes > 0) begin
         chk("last_addr", 64'(last_addr), 64'(v.exp_writes - 1));
         chk("done_after_write", 64'(done_cyc - prev_we_cyc), 64'd1);
         chk("busy_during_load", 64'(busy_low), 64'd0);
         bad = 0;
         for (int i = 0; i < v.exp_writes; i++) if (mem[i] !== words[i]) bad++;
         chk("mem_contents", 64'(bad), 64'd0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout actual=%0d required=finish", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{1,         1,     0,  1'b1, 32'h20020005, 1};
      vecs[1] = '{3,         3,     0,  1'b0, 32'h0,        3};
      vecs[2] = '{16,        16,    40, 1'b0, 32'h0,        16};
      vecs[3] = '{0,         0,     0,  1'b0, 32'h0,        0};
      vecs[4] = '{DEPTH + 5, DEPTH, 0,  1'b0, 32'h0,        DEPTH};
      vecs[5] = '{1,         1,     30, 1'b1, 32'h05000220, 1};

      rst = 1'b1; load_start = 1'b0; load_len = '0; in_valid = 1'b0; in_byte = 8'd0;
      wr_count = 0; busy_low = 0; spacing_chk = 1'b0; sum_be = 0; sum_le = 0;
      repeat (3) @(negedge clk);
      chk("rst_ctrl", {60'd0, cpu_rst, busy, in_ready, done}, {60'd0, 4'b1000});
      chk("rst_we", {63'd0, im_we}, 64'd0);
      chk("rst_addr", {54'd0, im_addr}, 64'd0);
      chk("rst_wdata", {32'd0, im_wdata}, 64'd0);
      chk("rst_checksum", {32'd0, checksum}, 64'd0);

      // reset and load_start together: reset must win
      load_start = 1'b1; load_len = 11'd4;
      @(negedge clk);
      load_start = 1'b0; rst = 1'b0;
      chk("rst_wins", {61'd0, cpu_rst, busy, in_ready}, {61'd0, 3'b100});

      for (int i = 0; i < 6; i++) begin
         run_vec(vecs[i]);
         if (i == 0) chk("be_fixed_word", {32'd0, im_wdata}, {32'd0, 32'h20020005});
      end
      chk("le_fixed_word", {32'd0, im_wdata_l}, {32'd0, 32'h20020005});

      // load_start during RECV is ignored
      words[0] = $urandom; words[1] = $urandom;
      spacing_chk = 1'b0;
      start_load(2);
      send_bytes(0, 5, 0);
      load_start = 1'b1; load_len = 11'd1;
      @(negedge clk);
      load_start = 1'b0;
      chk("ignore_start_ctrl", {61'd0, busy, in_ready, done}, {61'd0, 3'b110});
      send_bytes(5, 8, 0);
      wait_done();
      chk("ignore_start_writes", 64'(wr_count), 64'd2);
      chk("ignore_start_sum", {32'd0, checksum}, {32'd0, sum_be});
      chk("ignore_start_last", 64'(last_addr), 64'd1);

      // reset after the second byte of the second word of a 4-word load
      for (int i = 0; i < 4; i++) words[i] = $urandom;
      start_load(4);
      send_bytes(0, 6, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_ctrl", {60'd0, cpu_rst, busy, in_ready, done}, {60'd0, 4'b1000});
      chk("midrst_we", {63'd0, im_we}, 64'd0);
      chk("midrst_writes", 64'(wr_count), 64'd1);
      chk("midrst_sb", 64'(sb.size()), 64'd0);
      words[0] = $urandom;
      start_load(1);
      send_bytes(0, 4, 0);
      wait_done();
      chk("fresh_writes", 64'(wr_count), 64'd1);
      chk("fresh_addr", 64'(last_addr), 64'd0);
      chk("fresh_sum", {32'd0, checksum}, {32'd0, words[0]});
      chk("fresh_mem", {32'd0, mem[0]}, {32'd0, words[0]});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
